// File: rtl/vdma_frame_buf_sched.sv
// Triple-buffer frame scheduler for the multiport VDMA.
// Each channel rotates three frame buffers between writer, latest-complete
// and reader roles so the writer never touches the buffer being read and
// the reader always starts on the newest finished frame.

// Per-channel buffer rotation and address generation.
module vdma_fbs_lane #(
  parameter int               ASIZE      = 29,
  parameter int               FRAME_STEP = 2211840,
  parameter logic [ASIZE-1:0] CH_OFF     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_done,
  input  logic             rd_start,
  input  logic [ASIZE-1:0] base,
  output logic [ASIZE-1:0] wr_addr,
  output logic [ASIZE-1:0] rd_addr,
  output logic             drop,
  output logic             rpt
);
  logic [1:0]       w_q, w_d, l_q, l_d, r_q, r_d;
  logic             lv_q, lv_d;
  logic [ASIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic             drop_q, drop_d, rpt_q, rpt_d;

  // Buffer index to byte offset inside the channel region; index 3 never occurs.
  function automatic logic [ASIZE-1:0] foff(input logic [1:0] idx);
    case (idx)
      2'd0:    foff = '0;
      2'd1:    foff = ASIZE'(FRAME_STEP);
      default: foff = ASIZE'(2 * FRAME_STEP);
    endcase
  endfunction

  // Next-state rotation: indices stay a permutation of {0,1,2} in every branch.
  always_comb begin
    w_d    = w_q;
    l_d    = l_q;
    r_d    = r_q;
    lv_d   = lv_q;
    drop_d = 1'b0;
    rpt_d  = 1'b0;
    if (!en) begin
      w_d  = 2'd0;
      l_d  = 2'd1;
      r_d  = 2'd2;
      lv_d = 1'b0;
    end else if (wr_done && rd_start) begin
      // Finished frame goes straight to the reader; old read buffer becomes spare.
      w_d    = l_q;
      r_d    = w_q;
      l_d    = r_q;
      lv_d   = 1'b0;
      drop_d = lv_q;
    end else if (wr_done) begin
      w_d    = l_q;
      l_d    = w_q;
      lv_d   = 1'b1;
      drop_d = lv_q;
    end else if (rd_start) begin
      if (lv_q) begin
        r_d  = l_q;
        l_d  = r_q;
        lv_d = 1'b0;
      end else begin
        rpt_d = 1'b1;
      end
    end
    // Addresses use the next indices so they land on the same edge as the event.
    wr_addr_d = base + CH_OFF + foff(w_d);
    rd_addr_d = base + CH_OFF + foff(r_d);
  end

  // State, address and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q       <= 2'd0;
      l_q       <= 2'd1;
      r_q       <= 2'd2;
      lv_q      <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      drop_q    <= 1'b0;
      rpt_q     <= 1'b0;
    end else begin
      w_q       <= w_d;
      l_q       <= l_d;
      r_q       <= r_d;
      lv_q      <= lv_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      drop_q    <= drop_d;
      rpt_q     <= rpt_d;
    end
  end

  assign wr_addr = wr_addr_q;
  assign rd_addr = rd_addr_q;
  assign drop    = drop_q;
  assign rpt     = rpt_q;
endmodule

module vdma_frame_buf_sched #(
  parameter int ASIZE      = 29,
  parameter int NCH        = 8,
  parameter int FRAME_STEP = 2211840,
  parameter int CH_STRIDE  = 3 * FRAME_STEP
) (
  input  logic                 axi_aclk,
  input  logic                 axi_reset,
  input  logic [ASIZE-1:0]     region_base,
  input  logic [NCH-1:0]       ch_enable,
  input  logic [NCH-1:0]       wr_frame_done,
  input  logic [NCH-1:0]       rd_frame_start,
  output logic [NCH*ASIZE-1:0] wr_baseaddr,
  output logic [NCH*ASIZE-1:0] rd_baseaddr,
  output logic [NCH-1:0]       wr_drop,
  output logic [NCH-1:0]       rd_repeat
);
  // One independent scheduler per channel, each offset into its own region.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    vdma_fbs_lane #(
      .ASIZE     (ASIZE),
      .FRAME_STEP(FRAME_STEP),
      .CH_OFF    (ASIZE'(c * CH_STRIDE))
    ) u_lane (
      .clk     (axi_aclk),
      .rst     (axi_reset),
      .en      (ch_enable[c]),
      .wr_done (wr_frame_done[c]),
      .rd_start(rd_frame_start[c]),
      .base    (region_base),
      .wr_addr (wr_baseaddr[c*ASIZE +: ASIZE]),
      .rd_addr (rd_baseaddr[c*ASIZE +: ASIZE]),
      .drop    (wr_drop[c]),
      .rpt     (rd_repeat[c])
    );
  end
endmodule

// File: tb/tb_vdma_frame_buf_sched.sv
// Directed bench for vdma_frame_buf_sched: hand-computed addresses and pulses.
module tb_vdma_frame_buf_sched;
  localparam int ASIZE = 29;
  localparam int NCH   = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [ASIZE-1:0]     region_base;
  logic [NCH-1:0]       ch_enable, wr_frame_done, rd_frame_start;
  logic [NCH*ASIZE-1:0] wr_baseaddr, rd_baseaddr;
  logic [NCH-1:0]       wr_drop, rd_repeat;

  int checks   = 0;
  int failures = 0;
  bit inv_en   = 1'b0;

  vdma_frame_buf_sched dut (
    .axi_aclk      (clk),
    .axi_reset     (rst),
    .region_base   (region_base),
    .ch_enable     (ch_enable),
    .wr_frame_done (wr_frame_done),
    .rd_frame_start(rd_frame_start),
    .wr_baseaddr   (wr_baseaddr),
    .rd_baseaddr   (rd_baseaddr),
    .wr_drop       (wr_drop),
    .rd_repeat     (rd_repeat)
  );

  always #5 clk = ~clk;

  function automatic logic [ASIZE-1:0] wr_of(input int c);
    wr_of = wr_baseaddr[c*ASIZE +: ASIZE];
  endfunction
  function automatic logic [ASIZE-1:0] rd_of(input int c);
    rd_of = rd_baseaddr[c*ASIZE +: ASIZE];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1 time unit after the edge; also checks writer != reader.
  task automatic step();
    @(posedge clk);
    #1;
    if (inv_en)
      for (int c = 0; c < NCH; c++) begin
        checks++;
        assert (wr_of(c) !== rd_of(c)) else begin
          failures++;
          $error("FAIL inv_ch%0d observed=%h expected!=%h", c, wr_of(c), rd_of(c));
        end
      end
  endtask

  task automatic do_reset();
    inv_en         = 1'b0;
    rst            = 1'b1;
    wr_frame_done  = '0;
    rd_frame_start = '0;
    ch_enable      = '1;
    region_base    = '0;
    step();
    rst = 1'b0;
    step();
    inv_en = 1'b1;
  endtask

  initial begin
    rst = 1'b0; region_base = '0; ch_enable = '1;
    wr_frame_done = '0; rd_frame_start = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_wr",   64'(wr_baseaddr), 64'd0);
    chk("rst_rd",   64'(rd_baseaddr), 64'd0);
    chk("rst_drop", 64'(wr_drop),     64'd0);
    chk("rst_rpt",  64'(rd_repeat),   64'd0);

    // 1: idle after reset
    do_reset();
    chk("t1_wr0", 64'(wr_of(0)), 64'h0);
    chk("t1_rd0", 64'(rd_of(0)), 64'h438000);
    chk("t1_wr3", 64'(wr_of(3)), 64'h12FC000);
    chk("t1_rd3", 64'(rd_of(3)), 64'h1734000);
    chk("t1_pulses", 64'({wr_drop, rd_repeat}), 64'd0);

    // 2: write then read
    wr_frame_done[0] = 1'b1; step(); wr_frame_done[0] = 1'b0;
    chk("t2_wr0", 64'(wr_of(0)), 64'h21C000);
    chk("t2_rd0_hold", 64'(rd_of(0)), 64'h438000);
    chk("t2_drop", 64'(wr_drop), 64'd0);
    step(); step();
    rd_frame_start[0] = 1'b1; step(); rd_frame_start[0] = 1'b0;
    chk("t2_rd0", 64'(rd_of(0)), 64'h0);
    chk("t2_wr0_hold", 64'(wr_of(0)), 64'h21C000);
    chk("t2_pulses", 64'({wr_drop, rd_repeat}), 64'd0);

    // 3: read with no fresh frame
    do_reset();
    rd_frame_start[1] = 1'b1; step(); rd_frame_start[1] = 1'b0;
    chk("t3_rpt", 64'(rd_repeat), 64'h02);
    chk("t3_rd1", 64'(rd_of(1)), 64'hA8C000);
    step();
    chk("t3_rpt_end", 64'(rd_repeat), 64'h00);

    // 4: two writes, no read
    do_reset();
    wr_frame_done[0] = 1'b1; step(); wr_frame_done[0] = 1'b0;
    chk("t4_wr0_a", 64'(wr_of(0)), 64'h21C000);
    chk("t4_drop_a", 64'(wr_drop), 64'h00);
    wr_frame_done[0] = 1'b1; step(); wr_frame_done[0] = 1'b0;
    chk("t4_wr0_b", 64'(wr_of(0)), 64'h0);
    chk("t4_drop_b", 64'(wr_drop), 64'h01);
    step();
    chk("t4_drop_end", 64'(wr_drop), 64'h00);

    // 5: simultaneous write-done and read-start
    do_reset();
    wr_frame_done[2] = 1'b1; rd_frame_start[2] = 1'b1; step();
    wr_frame_done[2] = 1'b0; rd_frame_start[2] = 1'b0;
    chk("t5_wr2", 64'(wr_of(2)), 64'hEC4000);
    chk("t5_rd2", 64'(rd_of(2)), 64'hCA8000);
    chk("t5_pulses", 64'({wr_drop, rd_repeat}), 64'd0);
    rd_frame_start[2] = 1'b1; step(); rd_frame_start[2] = 1'b0;
    chk("t5_rpt", 64'(rd_repeat), 64'h04);
    chk("t5_rd2_hold", 64'(rd_of(2)), 64'hCA8000);

    // 6: disable mid-operation with concurrent event and wrapping base
    do_reset();
    wr_frame_done[0] = 1'b1; step(); wr_frame_done[0] = 1'b0;
    chk("t6_pre_wr0", 64'(wr_of(0)), 64'h21C000);
    ch_enable[0] = 1'b0; wr_frame_done[0] = 1'b1; region_base = 29'h1FFFFFFF;
    step();
    ch_enable[0] = 1'b1; wr_frame_done[0] = 1'b0;
    chk("t6_wr0", 64'(wr_of(0)), 64'h1FFFFFFF);
    chk("t6_rd0", 64'(rd_of(0)), 64'h437FFF);
    chk("t6_wr1", 64'(wr_of(1)), 64'h653FFF);
    chk("t6_drop", 64'(wr_drop), 64'd0);
    step();
    chk("t6_wr0_idle", 64'(wr_of(0)), 64'h1FFFFFFF);
    chk("t6_pulses", 64'({wr_drop, rd_repeat}), 64'd0);
    // event after re-enable behaves as from reset: no drop
    wr_frame_done[0] = 1'b1; step(); wr_frame_done[0] = 1'b0;
    chk("t6_post_wr0", 64'(wr_of(0)), 64'h0021BFFF);
    chk("t6_post_drop", 64'(wr_drop), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vdma_frame_buf_sched.md
Name: vdma_frame_buf_sched

Overview:
Per-channel triple-buffer scheduler for the multiport VDMA. It generates the write and read frame base addresses that drive the VDMA channel ports.
- The writer always owns a buffer distinct from the reader's.
- The reader always picks up the newest completed frame.
- Writer/reader rate mismatches are reported as per-channel drop and repeat pulses.
- Sits between the channel frame-sync logic and the VDMA wrapper's baseaddr inputs, replacing the static address assignment.

Parameters:
ASIZE, 29, DDR address width.
NCH, 8, number of channels.
FRAME_STEP, 2211840 (256*8*1080, 0x21C000), address span of one frame buffer.
CH_STRIDE, 3*FRAME_STEP (0x654000), address span of one channel region.

Ports:
axi_aclk  in  1  clock.
axi_reset  in  1  asynchronous, active-high reset.
region_base  in  ASIZE  base of the whole frame-buffer region.
ch_enable  in  NCH  per-channel enable.
wr_frame_done  in  NCH  1-cycle pulse: writer finished a frame.
rd_frame_start  in  NCH  1-cycle pulse: reader starting a frame.
wr_baseaddr  out  NCH*ASIZE  packed; channel c in bits [c*ASIZE +: ASIZE]; write buffer base.
rd_baseaddr  out  NCH*ASIZE  packed; channel c in bits [c*ASIZE +: ASIZE]; read buffer base.
wr_drop  out  NCH  1-cycle pulse: an unread completed frame was overwritten.
rd_repeat  out  NCH  1-cycle pulse: reader re-reads the previous frame.

Behaviour:
- Per-channel state: 2-bit indices w (write), l (latest), r (read), always a permutation of {0,1,2}; flag lv (l holds an unread frame).
- Reset (axi_reset=1, async): every channel w=0, l=1, r=2, lv=0; all outputs 0.
- ch_enable[c]=0: channel c is synchronously forced to the reset state each cycle. Its events are ignored and its pulses stay 0. Address outputs still follow the formula below.
- Events, sampled at a rising edge with ch_enable[c]=1:
  - wr_frame_done only: w<=l, l<=w, lv<=1. wr_drop pulses if lv was 1.
  - rd_frame_start only, lv=1: r<=l, l<=r, lv<=0.
  - rd_frame_start only, lv=0: no index change; rd_repeat pulses.
  - Both in the same cycle: w<=l_old, r<=w_old, l<=r_old, lv<=0. wr_drop pulses if lv_old=1. No rd_repeat.
  - Neither: hold.
- Addresses, registered every cycle:
  - wr_baseaddr[c] = region_base + c*CH_STRIDE + w_next*FRAME_STEP.
  - rd_baseaddr[c] = region_base + c*CH_STRIDE + r_next*FRAME_STEP.
  - Arithmetic is truncated modulo 2^ASIZE; no saturation.
  - Latency: an event or region_base change is visible on the outputs on the edge that samples it, i.e. the cycle after the pulse.
- Pulses: registered, asserted for exactly the cycle after the event.
- Pulses wider than 1 cycle are treated as repeated events; the driver guarantees single-cycle pulses.
- Invariant: w != r at all times, including during simultaneous events. Verification asserts this.
- Reset deasserting mid-frame: the channel restarts from the reset indices. No drop or repeat is reported for the aborted frame.

Test Plan:
1. Reset, region_base=0, ch_enable=0xFF, one idle cycle -> ch0 wr=0x000000, rd=0x438000; ch3 wr=0x12FC000, rd=0x1734000; no pulses.
2. ch0 wr_frame_done, then 3 cycles later rd_frame_start -> after first pulse wr=0x21C000; after second rd=0x000000; no wr_drop, no rd_repeat.
3. From reset, ch1 rd_frame_start alone -> rd_repeat[1]=1 for one cycle; rd stays 0x654000+0x438000=0xA8C000.
4. From reset, ch0 wr_frame_done twice with no read -> wr goes 0x21C000 then 0x000000; wr_drop[0] pulses only after the second.
5. From reset, ch2 wr_frame_done and rd_frame_start in the same cycle -> wr=0xCA8000+0x21C000=0xEC4000, rd=0xCA8000; no pulses; a following rd_frame_start gives rd_repeat[2].
6. Mid-operation, drop ch0 enable for 1 cycle with a concurrent wr_frame_done; set region_base=0x1FFFFFFF with ASIZE=29 -> ch0 returns to wr=region_base, rd=region_base+0x438000 mod 2^29 (0x00437FFF); event ignored; no pulse.
